// File: rtl/dna_pkg.sv
// Shared constants and types for the soft DNA_PORT responder.
// Also home to the reader-side ID width so both ends agree.
package dna_pkg;

  localparam int DNA_DATA_WIDTH    = 57;
  localparam int DNA_SYNC_STAGES   = 2;
  localparam int DNA_BIT_CNT_WIDTH = 7;
  localparam int DNA_SETTLE_WIDTH  = $clog2(DNA_SYNC_STAGES + 2);
  localparam int DNA_READER_WIDTH  = DNA_DATA_WIDTH;

  typedef struct packed {
    logic read;
    logic shift;
    logic din;
  } dna_ctl_t;

  function automatic logic [DNA_BIT_CNT_WIDTH-1:0] dna_cnt_inc(
    input logic [DNA_BIT_CNT_WIDTH-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/dna_sync.sv
// Synchronizes the serial pins into aclk and detects dna_clk rises.
// Rises are masked until the chain has flushed after reset.
module dna_sync
  import dna_pkg::*;
#(
  parameter int N        = 3,
  parameter int STAGES   = DNA_SYNC_STAGES,
  parameter int SETTLE_W = DNA_SETTLE_WIDTH
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_clk,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data,
  output logic         o_rise
);

  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(STAGES + 1);

  logic [STAGES-1:0]        r_csync;
  logic [STAGES-1:0][N-1:0] r_dsync;
  logic                     r_prev;
  logic [SETTLE_W-1:0]      r_settle;
  logic                     w_settled;

  assign w_settled = (r_settle == SETTLE_DONE);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_csync  <= '0;
      r_dsync  <= '0;
      r_prev   <= 1'b0;
      r_settle <= '0;
    end else begin
      r_csync <= {r_csync[STAGES-2:0], i_clk};
      r_dsync <= {r_dsync[STAGES-2:0], i_data};
      r_prev  <= r_csync[STAGES-1];
      if (!w_settled)
        r_settle <= r_settle + 1'b1;
    end
  end

  assign o_data = r_dsync[STAGES-1];
  assign o_rise = w_settled & r_csync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/dna_responder.sv
// Device side of the DNA_PORT serial-ID protocol in fabric logic.
// Loads a programmable ID and shifts it out MSB first on dna_clk.
module dna_responder
  import dna_pkg::*;
#(
  parameter int DATA_WIDTH  = DNA_DATA_WIDTH,
  parameter int SYNC_STAGES = DNA_SYNC_STAGES
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [DATA_WIDTH-1:0]        dna_id,
  input  logic                         dna_clk,
  input  logic                         dna_read,
  input  logic                         dna_shift,
  input  logic                         dna_din,
  output logic                         dna_dout,
  output logic [DNA_BIT_CNT_WIDTH-1:0] bit_count,
  output logic                         done,
  output logic                         overrun
);

  localparam int CW = DNA_BIT_CNT_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  dna_ctl_t w_ctl;
  logic     w_rise;
  logic     w_load;
  logic     w_shift;

  logic [DATA_WIDTH-1:0] r_sreg;
  logic [DATA_WIDTH-1:0] w_sreg_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  r_dout;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_ovr;
  logic                  w_ovr_nxt;

  dna_sync #(
    .N        (3),
    .STAGES   (SYNC_STAGES),
    .SETTLE_W ($clog2(SYNC_STAGES + 2))
  ) u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_clk   (dna_clk),
    .i_data  ({dna_read, dna_shift, dna_din}),
    .o_data  (w_ctl),
    .o_rise  (w_rise)
  );

  // read has priority over shift on the same edge
  assign w_load  = w_rise & w_ctl.read;
  assign w_shift = w_rise & ~w_ctl.read & w_ctl.shift;

  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    w_ovr_nxt  = r_ovr;
    w_done_nxt = 1'b0;
    unique case (1'b1)
      w_load: begin
        w_sreg_nxt = dna_id;
        w_cnt_nxt  = '0;
        w_ovr_nxt  = 1'b0;
      end
      w_shift: begin
        w_sreg_nxt = {r_sreg[DATA_WIDTH-2:0], w_ctl.din};
        w_cnt_nxt  = dna_cnt_inc(r_cnt);
        w_ovr_nxt  = r_ovr | (r_cnt >= LAST);
        w_done_nxt = (r_cnt != LAST) && (w_cnt_nxt == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sreg <= '0;
      r_dout <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_dout <= w_sreg_nxt[DATA_WIDTH-1];
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  assign dna_dout  = r_dout;
  assign bit_count = r_cnt;
  assign done      = r_done;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_dna_responder.sv
// Bench for dna_responder: reader-style serial transfers with a
// per-edge expectation queue plus scenario checks.
module tb_dna_responder;
  import dna_pkg::*;

  localparam int DW = 57;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] dna_id = '0;
  logic          dna_clk = 1'b0;
  logic          dna_read = 1'b0;
  logic          dna_shift = 1'b0;
  logic          dna_din = 1'b0;
  logic          dna_dout;
  logic [6:0]    bit_count;
  logic          done;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic       dout;
    logic [6:0] cnt;
    logic       ovr;
  } exp_t;

  exp_t sb[$];

  logic [DW-1:0] m_sreg;
  logic [6:0]    m_cnt;
  logic          m_ovr;

  always #5 aclk = ~aclk;

  always @(negedge aclk)
    if (done === 1'b1) done_cnt++;

  dna_responder dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .dna_id    (dna_id),
    .dna_clk   (dna_clk),
    .dna_read  (dna_read),
    .dna_shift (dna_shift),
    .dna_din   (dna_din),
    .dna_dout  (dna_dout),
    .bit_count (bit_count),
    .done      (done),
    .overrun   (overrun)
  );

  task automatic wait_n(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // one reader cycle: 32 low (sample 1 before rise), 32 high
  task automatic do_edge(input logic rd, input logic sh,
                         input logic di, output logic pre);
    exp_t e;
    dna_read  = rd;
    dna_shift = sh;
    dna_din   = di;
    wait_n(31);
    pre = dna_dout;
    wait_n(1);
    dna_clk = 1'b1;
    if (rd) begin
      m_sreg = dna_id;
      m_cnt  = '0;
      m_ovr  = 1'b0;
    end else if (sh) begin
      m_ovr  = m_ovr | (m_cnt >= 7'(DW - 1));
      m_sreg = {m_sreg[DW-2:0], di};
      if (m_cnt != 7'd127) m_cnt = m_cnt + 7'd1;
    end
    e.dout = m_sreg[DW-1];
    e.cnt  = m_cnt;
    e.ovr  = m_ovr;
    sb.push_back(e);
    wait_n(32);
    dna_clk = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    m_sreg = '0;
    m_cnt  = '0;
    m_ovr  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      dna_clk   = ~dna_clk;
      dna_read  = 1'($urandom_range(1));
      dna_shift = 1'($urandom_range(1));
      dna_din   = ~dna_din;
      dna_id    = {25'($urandom), 32'($urandom)};
      checks++;
      if ({dna_dout, bit_count, done, overrun} !== 10'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got dout=%b cnt=%0d done=%b ovr=%b want all 0",
                 i, dna_dout, bit_count, done, overrun);
      end
    end
    aresetn   = 1'b1;
    dna_clk   = 1'b0;
    dna_read  = 1'b0;
    dna_shift = 1'b0;
    dna_din   = 1'b0;
    @(negedge aclk);
    checks++;
    if ({dna_dout, bit_count, done, overrun} !== 10'd0) begin
      failures++;
      $display("FAIL reset_release: got dout=%b cnt=%0d done=%b ovr=%b want all 0",
               dna_dout, bit_count, done, overrun);
    end
    wait_n(10);
  endtask

  task automatic test_full_read();
    logic [DW-1:0] bits;
    logic          pre;
    int            d0;
    int            d_pre_last;
    exp_t          e;
    dna_id = 57'h1_DEAD_BEEF_CAFE_01;
    d0 = done_cnt;
    d_pre_last = 0;
    do_edge(1'b1, 1'b0, 1'b0, pre);
    e = sb.pop_front();
    checks++;
    if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
      failures++;
      $display("FAIL full_load: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
               dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
    end
    for (int i = 0; i < DW - 1; i++) begin
      if (i == DW - 2) d_pre_last = done_cnt;
      do_edge(1'b0, 1'b1, 1'b0, pre);
      bits[DW-1-i] = pre;
      e = sb.pop_front();
      checks++;
      if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
        failures++;
        $display("FAIL full_shift[%0d]: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
                 i, dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
      end
    end
    bits[0] = dna_dout;
    checks++;
    if (bits !== dna_id) begin
      failures++;
      $display("FAIL full_bits: got %h want %h", bits, dna_id);
    end
    checks++;
    if (d_pre_last != d0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL full_done: got %0d before last, %0d total want 0 and 1",
               d_pre_last - d0, done_cnt - d0);
    end
    checks++;
    if (bit_count !== 7'd56 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL full_end: got cnt=%0d ovr=%b want cnt=56 ovr=0",
               bit_count, overrun);
    end
  endtask

  task automatic test_idle_edge();
    logic pre;
    exp_t e;
    dna_id = 57'h1_2345_6789_ABCD_EF;
    do_edge(1'b1, 1'b0, 1'b0, pre);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      do_edge(1'b0, 1'b1, 1'b0, pre);
      void'(sb.pop_front());
    end
    do_edge(1'b0, 1'b0, 1'b1, pre);
    e = sb.pop_front();
    checks++;
    if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
      failures++;
      $display("FAIL idle_edge: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
               dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
    end
    dna_id = ~dna_id;
    wait_n(40);
    checks++;
    if (dna_dout !== m_sreg[DW-1] || bit_count !== 7'd3) begin
      failures++;
      $display("FAIL idle_id_change: got dout=%b cnt=%0d want dout=%b cnt=3",
               dna_dout, bit_count, m_sreg[DW-1]);
    end
    for (int i = 0; i < 8; i++) begin
      do_edge(1'b0, 1'b1, 1'b0, pre);
      e = sb.pop_front();
      checks++;
      if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
        failures++;
        $display("FAIL idle_shift[%0d]: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
                 i, dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
      end
    end
  endtask

  task automatic test_overshift();
    logic pre;
    int   d0;
    exp_t e;
    dna_id = '0;
    do_edge(1'b1, 1'b0, 1'b0, pre);
    void'(sb.pop_front());
    d0 = done_cnt;
    for (int i = 1; i <= 200; i++) begin
      do_edge(1'b0, 1'b1, 1'b1, pre);
      e = sb.pop_front();
      checks++;
      if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
        failures++;
        $display("FAIL over_shift[%0d]: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
                 i, dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
      end
      if (i == 56) begin
        checks++;
        if (dna_dout !== 1'b0 || overrun !== 1'b0) begin
          failures++;
          $display("FAIL over_56: got dout=%b ovr=%b want 0 0", dna_dout, overrun);
        end
      end
      if (i == 57) begin
        checks++;
        if (dna_dout !== 1'b1 || overrun !== 1'b1) begin
          failures++;
          $display("FAIL over_57: got dout=%b ovr=%b want 1 1", dna_dout, overrun);
        end
      end
      if (i == 60) begin
        checks++;
        if (bit_count !== 7'd60 || done_cnt - d0 != 1) begin
          failures++;
          $display("FAIL over_60: got cnt=%0d done=%0d want 60 1",
                   bit_count, done_cnt - d0);
        end
      end
    end
    checks++;
    if (bit_count !== 7'd127 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL over_sat: got cnt=%0d done=%0d want 127 1",
               bit_count, done_cnt - d0);
    end
  endtask

  task automatic test_read_shift_both();
    logic pre;
    exp_t e;
    dna_id = 57'h0_0000_0000_0000_01;
    do_edge(1'b1, 1'b1, 1'b1, pre);
    e = sb.pop_front();
    checks++;
    if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
      failures++;
      $display("FAIL both_edge: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
               dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
    end
    checks++;
    if (bit_count !== 7'd0 || dna_dout !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL both_load: got cnt=%0d dout=%b ovr=%b want 0 0 0",
               bit_count, dna_dout, overrun);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic pre;
    int   d0;
    exp_t e;
    dna_id = '1;
    do_edge(1'b1, 1'b0, 1'b0, pre);
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      do_edge(1'b0, 1'b1, 1'b1, pre);
      void'(sb.pop_front());
    end
    d0 = done_cnt;
    dna_read  = 1'b0;
    dna_shift = 1'b1;
    dna_din   = 1'b1;
    wait_n(8);
    dna_clk = 1'b1;
    aresetn = 1'b0;
    wait_n(5);
    checks++;
    if ({dna_dout, bit_count, done, overrun} !== 10'd0) begin
      failures++;
      $display("FAIL rst_mid_hold: got dout=%b cnt=%0d done=%b ovr=%b want all 0",
               dna_dout, bit_count, done, overrun);
    end
    aresetn = 1'b1;
    m_sreg = '0;
    m_cnt  = '0;
    m_ovr  = 1'b0;
    wait_n(40);
    checks++;
    if ({dna_dout, bit_count, done, overrun} !== 10'd0 || done_cnt != d0) begin
      failures++;
      $display("FAIL rst_mid_release: got dout=%b cnt=%0d ovr=%b dpulses=%0d want all 0",
               dna_dout, bit_count, overrun, done_cnt - d0);
    end
    dna_clk = 1'b0;
    do_edge(1'b0, 1'b1, 1'b0, pre);
    e = sb.pop_front();
    checks++;
    if (dna_dout !== e.dout || bit_count !== e.cnt || overrun !== e.ovr) begin
      failures++;
      $display("FAIL rst_mid_next: got dout=%b cnt=%0d ovr=%b want dout=%b cnt=%0d ovr=%b",
               dna_dout, bit_count, overrun, e.dout, e.cnt, e.ovr);
    end
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_idle_edge();
    test_overshift();
    test_read_shift_both();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
